// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the byte-enabled data-memory port: grant, one-cycle issue,
// read-latency wait, response. Define DM_ARB_STAT_EN to add grant/conflict statistics counters.
module dm_port_arbiter #(
    parameter int READ_LAT = 1,
    parameter int RR_EN    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_byteen,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteen,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic        m_data_rd,
    input  logic [31:0] m_data_rdata,
`ifdef DM_ARB_STAT_EN
    output logic [31:0] stat_c_grants,
    output logic [31:0] stat_d_grants,
    output logic [31:0] stat_conflicts,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic       OWN_C = 1'b0;
    localparam logic       OWN_D = 1'b1;
    localparam logic [2:0] LAT   = 3'(READ_LAT);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  byteen_q, byteen_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] c_rdata_q, c_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        grant_c, grant_d;
    logic        issue;

    // Grants are gated by reset so nothing is handed out while the port is held in reset.
    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE && reset) begin
            if (c_req && d_req) begin
                if (RR_EN != 0 && last_owner_q == OWN_C) grant_d = 1'b1;
                else                                     grant_c = 1'b1;
            end else if (c_req) begin
                grant_c = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        byteen_d     = byteen_q;
        cnt_d        = cnt_q;
        c_rdata_d    = c_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_c || grant_d) begin
                    owner_d      = grant_d ? OWN_D : OWN_C;
                    last_owner_d = grant_d ? OWN_D : OWN_C;
                    addr_d       = grant_d ? d_addr   : c_addr;
                    wdata_d      = grant_d ? d_wdata  : c_wdata;
                    byteen_d     = grant_d ? d_byteen : c_byteen;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (byteen_q == 4'b0000) begin
                    state_d = WAIT;
                    cnt_d   = LAT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Memory data is valid in the cycle the counter reads 1.
                if (cnt_q <= 3'd1) begin
                    if (owner_q == OWN_D) d_rdata_d = m_data_rdata;
                    else                  c_rdata_d = m_data_rdata;
                    cnt_d   = 3'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_C;
            last_owner_q <= OWN_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            byteen_q     <= '0;
            cnt_q        <= '0;
            c_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            byteen_q     <= byteen_d;
            cnt_q        <= cnt_d;
            c_rdata_q    <= c_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign issue         = (state_q == ISSUE);
    assign m_data_addr   = issue ? addr_q   : 32'd0;
    assign m_data_wdata  = issue ? wdata_q  : 32'd0;
    assign m_data_byteen = issue ? byteen_q : 4'd0;
    assign m_data_rd     = issue && (byteen_q == 4'b0000);
    assign c_gnt         = grant_c;
    assign d_gnt         = grant_d;
    assign c_rvalid      = (state_q == RESP) && (owner_q == OWN_C);
    assign d_rvalid      = (state_q == RESP) && (owner_q == OWN_D);
    assign c_rdata       = c_rdata_q;
    assign d_rdata       = d_rdata_q;
    assign busy          = (state_q != IDLE);

`ifdef DM_ARB_STAT_EN
    logic [31:0] stat_c_q, stat_c_d;
    logic [31:0] stat_d_q, stat_d_d;
    logic [31:0] stat_x_q, stat_x_d;

    // Every cycle with both requests pending is a conflict, since at most one is ever granted.
    always_comb begin
        stat_c_d = stat_c_q + 32'(grant_c);
        stat_d_d = stat_d_q + 32'(grant_d);
        stat_x_d = stat_x_q + 32'(c_req && d_req);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_c_q <= '0;
            stat_d_q <= '0;
            stat_x_q <= '0;
        end else begin
            stat_c_q <= stat_c_d;
            stat_d_q <= stat_d_d;
            stat_x_q <= stat_x_d;
        end
    end

    assign stat_c_grants  = stat_c_q;
    assign stat_d_grants  = stat_d_q;
    assign stat_conflicts = stat_x_q;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: a round-robin instance and a fixed-priority instance,
// both with READ_LAT = 2. Statistics checks compile in when DM_ARB_STAT_EN is defined.
module tb_dm_port_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic        c_req, d_req, c_gnt, d_gnt, c_rvalid, d_rvalid, m_data_rd, busy;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata, c_rdata, d_rdata;
    logic [3:0]  c_byteen, d_byteen, m_data_byteen;
    logic [31:0] m_data_addr, m_data_wdata, m_rdata;

    logic        fp_c_req, fp_d_req, fp_c_gnt, fp_d_gnt, fp_c_rvalid, fp_d_rvalid, fp_m_rd, fp_busy;
    logic [31:0] fp_c_addr, fp_c_wdata, fp_d_addr, fp_d_wdata, fp_c_rdata, fp_d_rdata;
    logic [3:0]  fp_c_byteen, fp_d_byteen, fp_m_byteen;
    logic [31:0] fp_m_addr, fp_m_wdata, fp_m_rdata;

`ifdef DM_ARB_STAT_EN
    logic [31:0] stat_c_grants, stat_d_grants, stat_conflicts;
    logic [31:0] fp_stat_c, fp_stat_d, fp_stat_x;
`endif

    dm_port_arbiter #(.READ_LAT(2), .RR_EN(1)) dut_rr (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_byteen(c_byteen),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_data_rd(m_data_rd), .m_data_rdata(m_rdata),
`ifdef DM_ARB_STAT_EN
        .stat_c_grants(stat_c_grants), .stat_d_grants(stat_d_grants),
        .stat_conflicts(stat_conflicts),
`endif
        .busy(busy)
    );

    dm_port_arbiter #(.READ_LAT(2), .RR_EN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .c_req(fp_c_req), .c_addr(fp_c_addr), .c_wdata(fp_c_wdata), .c_byteen(fp_c_byteen),
        .c_gnt(fp_c_gnt), .c_rvalid(fp_c_rvalid), .c_rdata(fp_c_rdata),
        .d_req(fp_d_req), .d_addr(fp_d_addr), .d_wdata(fp_d_wdata), .d_byteen(fp_d_byteen),
        .d_gnt(fp_d_gnt), .d_rvalid(fp_d_rvalid), .d_rdata(fp_d_rdata),
        .m_data_addr(fp_m_addr), .m_data_wdata(fp_m_wdata),
        .m_data_byteen(fp_m_byteen), .m_data_rd(fp_m_rd), .m_data_rdata(fp_m_rdata),
`ifdef DM_ARB_STAT_EN
        .stat_c_grants(fp_stat_c), .stat_d_grants(fp_stat_d), .stat_conflicts(fp_stat_x),
`endif
        .busy(fp_busy)
    );

    int test_count = 0;
    int fail_count = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cr, input logic [31:0] ca, input logic [31:0] cw,
                                 input logic [3:0] cb, input logic dr, input logic [31:0] da,
                                 input logic [31:0] dw, input logic [3:0] db);
        c_req = cr; c_addr = ca; c_wdata = cw; c_byteen = cb;
        d_req = dr; d_addr = da; d_wdata = dw; d_byteen = db;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    int          rr_c, rr_d, fp_c, fp_d, rr_n, fp_n;
    int          rr_order[8], fp_order[8], rr_cyc[8];
    logic [31:0] rr_expw;
    logic        rr_pend;

    initial begin
        reset = 1'b0;
        m_rdata = 32'h0;
        fp_m_rdata = 32'h0;
        fp_c_req = 1'b0; fp_c_addr = '0; fp_c_wdata = '0; fp_c_byteen = '0;
        fp_d_req = 1'b0; fp_d_addr = '0; fp_d_wdata = '0; fp_d_byteen = '0;
        applyStimulus(1'b1, 32'h1002, 32'hABCD_0000, 4'b1100, 1'b0, 32'h0, 32'h0, 4'h0);

        // Held in reset with a request pending: every output stays low.
        nextCycle(); #1;
        checkOutput("rstCGnt", {31'd0, c_gnt}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstMAddr", m_data_addr, 32'd0);
        checkOutput("rstCRdata", c_rdata, 32'd0);

        // C write.
        nextCycle(); reset = 1'b1; #1;
        checkOutput("wrCGnt", {31'd0, c_gnt}, 32'd1);
        checkOutput("wrDGnt", {31'd0, d_gnt}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        checkOutput("wrMAddr", m_data_addr, 32'h0000_1002);
        checkOutput("wrMByteen", {28'd0, m_data_byteen}, 32'h0000_000C);
        checkOutput("wrMWdata", m_data_wdata, 32'hABCD_0000);
        checkOutput("wrMRd", {31'd0, m_data_rd}, 32'd0);
        checkOutput("wrBusy", {31'd0, busy}, 32'd1);
        nextCycle(); #1;
        checkOutput("wrIdle", {31'd0, busy}, 32'd0);
        checkOutput("wrMByteenOff", {28'd0, m_data_byteen}, 32'd0);

        // D read, READ_LAT = 2.
        nextCycle();
        m_rdata = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h40, 32'h0, 4'h0); #1;
        checkOutput("rdDGnt", {31'd0, d_gnt}, 32'd1);
        checkOutput("rdCGnt", {31'd0, c_gnt}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        checkOutput("rdMRd1", {31'd0, m_data_rd}, 32'd1);
        checkOutput("rdMAddr", m_data_addr, 32'h40);
        checkOutput("rdMByteen", {28'd0, m_data_byteen}, 32'd0);
        nextCycle(); #1;
        checkOutput("rdMRd2", {31'd0, m_data_rd}, 32'd0);
        checkOutput("rdBusy2", {31'd0, busy}, 32'd1);
        nextCycle(); m_rdata = 32'h1234_5678; #1;
        checkOutput("rdDRvalid3", {31'd0, d_rvalid}, 32'd0);
        nextCycle(); m_rdata = 32'hFFFF_FFFF; #1;
        checkOutput("rdDRvalid4", {31'd0, d_rvalid}, 32'd1);
        checkOutput("rdDRdata4", d_rdata, 32'h1234_5678);
        checkOutput("rdCRvalid4", {31'd0, c_rvalid}, 32'd0);
        nextCycle(); #1;
        checkOutput("rdDRvalid5", {31'd0, d_rvalid}, 32'd0);
        checkOutput("rdBusy5", {31'd0, busy}, 32'd0);
        checkOutput("rdDRdataHold", d_rdata, 32'h1234_5678);
        checkOutput("rdCRdata", c_rdata, 32'd0);

        // Contention: four writes each on both instances at once.
        rr_c = 0; rr_d = 0; fp_c = 0; fp_d = 0; rr_n = 0; fp_n = 0; rr_pend = 1'b0;
        rr_expw = '0;
        for (int i = 0; i < 8; i++) begin
            rr_order[i] = -1; fp_order[i] = -1; rr_cyc[i] = -1;
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            nextCycle();
            if (rr_pend) begin
                checkOutput("rrIssueWdata", m_data_wdata, rr_expw);
                rr_pend = 1'b0;
            end
            applyStimulus(rr_c < 4, 32'h100 + 32'(rr_c), 32'hC000_0000 + 32'(rr_c), 4'hF,
                          rr_d < 4, 32'h200 + 32'(rr_d), 32'hD000_0000 + 32'(rr_d), 4'hF);
            fp_c_req = (fp_c < 4); fp_c_addr = 32'h300 + 32'(fp_c);
            fp_c_wdata = 32'hCC00_0000 + 32'(fp_c); fp_c_byteen = 4'hF;
            fp_d_req = (fp_d < 4); fp_d_addr = 32'h400 + 32'(fp_d);
            fp_d_wdata = 32'hDD00_0000 + 32'(fp_d); fp_d_byteen = 4'hF;
            #1;
            checkOutput("rrOneGnt", {31'd0, c_gnt & d_gnt}, 32'd0);
            checkOutput("fpOneGnt", {31'd0, fp_c_gnt & fp_d_gnt}, 32'd0);
            if (c_gnt || d_gnt) begin
                if (rr_n < 8) begin
                    rr_order[rr_n] = c_gnt ? 0 : 1;
                    rr_cyc[rr_n] = cyc;
                end
                rr_n++;
                rr_expw = c_gnt ? c_wdata : d_wdata;
                rr_pend = 1'b1;
                if (c_gnt) rr_c++; else rr_d++;
            end
            if (fp_c_gnt || fp_d_gnt) begin
                if (fp_n < 8) fp_order[fp_n] = fp_c_gnt ? 0 : 1;
                fp_n++;
                if (fp_c_gnt) fp_c++; else fp_d++;
            end
        end
        checkOutput("rrGrantCount", 32'(rr_n), 32'd8);
        checkOutput("fpGrantCount", 32'(fp_n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("rrOrder%0d", i), 32'(rr_order[i]), 32'(i % 2));
            checkOutput($sformatf("rrGntCycle%0d", i), 32'(rr_cyc[i]), 32'(2 * i));
            checkOutput($sformatf("fpOrder%0d", i), 32'(fp_order[i]), (i < 4) ? 32'd0 : 32'd1);
        end

        // Reset during the WAIT phase of a C read.
        nextCycle();
        applyStimulus(1'b1, 32'h80, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        checkOutput("abCGnt", {31'd0, c_gnt}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        checkOutput("abMRd", {31'd0, m_data_rd}, 32'd1);
        nextCycle(); #1;
        checkOutput("abWaitBusy", {31'd0, busy}, 32'd1);
        reset = 1'b0; #1;
        checkOutput("abRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("abRstMRd", {31'd0, m_data_rd}, 32'd0);
        checkOutput("abRstMAddr", m_data_addr, 32'd0);
        checkOutput("abRstDRdata", d_rdata, 32'd0);
        nextCycle(); reset = 1'b1;
        applyStimulus(1'b1, 32'h84, 32'h55AA_55AA, 4'hF, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        checkOutput("abRelCGnt", {31'd0, c_gnt}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
            checkOutput($sformatf("abNoCRvalid%0d", i), {31'd0, c_rvalid}, 32'd0);
            if (i == 0) checkOutput("abRelWdata", m_data_wdata, 32'h55AA_55AA);
        end

`ifdef DM_ARB_STAT_EN
        // Three single-cycle contended requests after a fresh reset: C, D, C.
        nextCycle(); reset = 1'b0;
        nextCycle(); reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h500, 32'h1, 4'hF, 1'b1, 32'h600, 32'h2, 4'hF); #1;
            checkOutput($sformatf("stGntC%0d", k), {31'd0, c_gnt}, (k == 1) ? 32'd0 : 32'd1);
            nextCycle();
            applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
            nextCycle();
        end
        #1;
        checkOutput("statConflicts", stat_conflicts, 32'd3);
        checkOutput("statCGrants", stat_c_grants, 32'd2);
        checkOutput("statDGrants", stat_d_grants, 32'd1);
        checkOutput("statTotal", stat_c_grants + stat_d_grants, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single byte-enabled data-memory port (m_data_addr / m_data_wdata / m_data_byteen) between two requesters: the pipeline M stage (requester C) and a bridge/DMA master (requester D).
- Sequences each access: grant, one-cycle issue, read-latency wait, response.
- Round-robin on contention.
- Sits between the M-stage byte-enable formatter and the external data memory. Requesters present already-formatted byteen/wdata.

Parameters:
- READ_LAT, 1: memory read latency in cycles, legal 1..4.
- RR_EN, 1: 1 = round-robin on contention; 0 = fixed priority, C always wins.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  C request; payload held stable until c_gnt
- c_addr  in  32  C byte address
- c_wdata  in  32  C write data, lane-placed
- c_byteen  in  4  C byte enables; 4'b0000 = read
- c_gnt  out  1  C grant pulse
- c_rvalid  out  1  C read-data valid pulse
- c_rdata  out  32  C read data
- d_req, d_addr, d_wdata, d_byteen, d_gnt, d_rvalid, d_rdata: same as the C ports, for requester D
- m_data_addr  out  32  memory address
- m_data_wdata  out  32  memory write data
- m_data_byteen  out  4  memory byte enables; nonzero = write
- m_data_rd  out  1  memory read strobe
- m_data_rdata  in  32  memory read data
- busy  out  1  port occupied (state != IDLE)

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE, last_owner = D, WAIT counter = 0.
  - All outputs 0, including registered rdata.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - c_gnt/d_gnt are combinational and asserted only in IDLE.
  - Only one requester has req = 1: grant it.
  - Both have req = 1:
    - RR_EN = 1: grant the requester that is not last_owner.
    - RR_EN = 0: grant C.
  - At the grant edge: latch addr/wdata/byteen/owner, update last_owner, go to ISSUE.
  - Neither has req = 1: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - m_data_addr/m_data_wdata/m_data_byteen driven from the latched registers.
  - If the latched byteen = 0: m_data_rd = 1 and m_data_byteen = 0, then go to WAIT with counter = READ_LAT.
  - Otherwise (write): m_data_rd = 0, then go to IDLE.
- Outside ISSUE, all m_data_* outputs are 0.
- WAIT:
  - Decrement the counter each cycle.
  - Memory data is valid in the cycle the counter reads 1, i.e. READ_LAT cycles after ISSUE.
  - In that cycle, sample m_data_rdata into the owner's rdata register and go to RESP.
- RESP (1 cycle):
  - Owner's rvalid = 1. Non-owner's rvalid = 0.
  - rdata registers hold their value until the next read response for that requester.
  - Go to IDLE.
- Latency (grant at cycle T):
  - Write reaches memory at T+1. Next grant possible at T+2.
  - Read: m_data_rd at T+1, rvalid at T+2+READ_LAT. Next grant possible at T+3+READ_LAT.
- Withdrawn request: dropping req before grant is legal and has no effect. A requester never sees gnt without having req asserted in that cycle.
- A requester's req while another access is in flight: held off with no grant. It is served on return to IDLE.
- Reset mid-operation: the in-flight access is abandoned. No rvalid is generated. A write in ISSUE is suppressed if reset is asserted that cycle.
- Width: the address is passed through unaltered. The arbiter does not check byteen/address alignment; that is the requester's responsibility.

Optional Feature:
- Macro: DM_ARB_STAT_EN.
- Defined: adds outputs stat_c_grants [31:0], stat_d_grants [31:0] and stat_conflicts [31:0].
  - stat_c_grants / stat_d_grants increment on each grant to C / D.
  - stat_conflicts increments on each cycle in which both req = 1 and at most one requester is granted.
  - All counters wrap at 2^32 and are cleared by reset.
- Undefined: these ports and counters are absent. Arbitration behaviour is identical.

Test Plan:
- C write only, c_addr = 0x0000_1002, c_byteen = 4'b1100, c_wdata = 0xABCD_0000 -> c_gnt in cycle 0; in cycle 1, m_data_addr = 0x1002, m_data_byteen = 4'b1100, m_data_wdata = 0xABCD_0000; busy = 0 in cycle 2.
- D read, d_addr = 0x40, READ_LAT = 2, memory returns 0x1234_5678 -> m_data_rd = 1 in cycle 1 only; d_rvalid = 1 in cycle 4 with d_rdata = 0x1234_5678; c_rvalid stays 0.
- c_req and d_req held high continuously for 4 writes each, RR_EN = 1 -> grants alternate C, D, C, D, ..., C first; no cycle has both grants.
- Same stimulus with RR_EN = 0 -> all 4 C writes complete before the first d_gnt.
- Reset asserted during WAIT of a C read -> all outputs 0 immediately; no c_rvalid after release; next c_req is granted in the first cycle after reset release.
- DM_ARB_STAT_EN defined, 3 contended grant cycles -> stat_conflicts = 3, stat_c_grants + stat_d_grants = total grants.
